// File: rtl/jtag_scan_sequencer.sv
// jtag_scan_sequencer: runs one IR scan plus an optional DR scan per command on a 1149.1 TAP,
// driving registered TMS/TDI and collecting TDO into dr_out.
module jtag_scan_sequencer #(
    parameter int IR_LEN = 2,
    parameter int DR_MAX = 64,
    parameter int CNT_W  = 7
) (
    input  logic              TCK,
    input  logic              TRST_b,
    input  logic              start,
    input  logic [IR_LEN-1:0] ir_val,
    input  logic [CNT_W-1:0]  dr_len,
    input  logic [DR_MAX-1:0] dr_in,
    input  logic              tdo,
    output logic              tms,
    output logic              tdi,
    output logic              busy,
    output logic              done,
    output logic [DR_MAX-1:0] dr_out
);
    typedef enum logic [2:0] {
        RST_SEQ, IDLE, IR_HDR, IR_SHIFT, IR_TAIL, DR_HDR, DR_SHIFT, DR_TAIL
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n, len;
    logic [IR_LEN-1:0] ir_r, ir_sh;
    logic [DR_MAX-1:0] dr_r, dr_sh;
    logic              last, tms_n, tdi_n;

    assign last = cnt == '0;
    assign busy = state != IDLE;

    // RST_SEQ counts up through its six cycles; every other state counts down to 0.
    always_comb begin
        state_n = state;
        cnt_n   = last ? cnt : cnt - CNT_W'(1);
        case (state)
            RST_SEQ: begin
                state_n = cnt == CNT_W'(5) ? IDLE : RST_SEQ;
                cnt_n   = cnt == CNT_W'(5) ? '0 : cnt + CNT_W'(1);
            end
            IDLE: if (start) begin
                state_n = IR_HDR;
                cnt_n   = CNT_W'(3);
            end
            IR_HDR: if (last) begin
                state_n = IR_SHIFT;
                cnt_n   = CNT_W'(IR_LEN - 1);
            end
            IR_SHIFT: if (last) begin
                state_n = IR_TAIL;
                cnt_n   = CNT_W'(1);
            end
            IR_TAIL: if (last) begin
                state_n = len == '0 ? IDLE : DR_HDR;
                cnt_n   = len == '0 ? '0 : CNT_W'(2);
            end
            DR_HDR: if (last) begin
                state_n = DR_SHIFT;
                cnt_n   = len - CNT_W'(1);
            end
            DR_SHIFT: if (last) begin
                state_n = DR_TAIL;
                cnt_n   = CNT_W'(1);
            end
            default: if (last) state_n = IDLE;
        endcase
    end

    // Pin values are derived from the upcoming state so they register in step with it.
    always_comb begin
        ir_sh = ir_r >> (CNT_W'(IR_LEN - 1) - cnt_n);
        dr_sh = dr_r >> (len - CNT_W'(1) - cnt_n);
        tms_n = 1'b0;
        tdi_n = 1'b0;
        case (state_n)
            RST_SEQ:          tms_n = cnt_n < CNT_W'(5);
            IR_HDR:           tms_n = cnt_n >= CNT_W'(2);
            DR_HDR:           tms_n = cnt_n == CNT_W'(2);
            IR_TAIL, DR_TAIL: tms_n = cnt_n == CNT_W'(1);
            IR_SHIFT: begin
                tms_n = cnt_n == '0;
                tdi_n = ir_sh[0];
            end
            DR_SHIFT: begin
                tms_n = cnt_n == '0;
                tdi_n = dr_sh[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge TCK) begin
        if (!TRST_b) begin
            state  <= RST_SEQ;
            cnt    <= '0;
            tms    <= 1'b1;
            tdi    <= 1'b0;
            done   <= 1'b0;
            dr_out <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            tms   <= tms_n;
            tdi   <= tdi_n;
            done  <= state != IDLE && state != RST_SEQ && state_n == IDLE;
            if (state == IDLE && start) begin
                ir_r   <= ir_val;
                dr_r   <= dr_in;
                len    <= dr_len > CNT_W'(DR_MAX) ? CNT_W'(DR_MAX) : dr_len;
                dr_out <= '0;
            end else if (state == DR_SHIFT) begin
                dr_out <= dr_out | (DR_MAX'(tdo) << (len - CNT_W'(1) - cnt));
            end
        end
    end
endmodule
